mario_sprite_ctrl: RTL and testbench
====================================

# mario_sprite_ctrl

Sequencer for the six Mario pose ROMs (run/stand/jump × right/left). Once per video frame it decides pose, facing and run-animation phase. Every pixel clock it converts the beam position into a ROM read address, selects the matching ROM output one cycle later, and presents a registered palette index with a sprite-hit flag to the color mapper. It sits between the ball/motion logic and the palette ROM in the VGA pixel path.

## Interface
Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 24, sprite height in pixels; SPR_W*SPR_H must be ≤ 480
- RUN_PERIOD, 6, frame ticks per run-animation phase; must be ≥ 1

Ports:
- Clk  in  1  pixel/system clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, issued during vertical blank
- move_left  in  1  left input held
- move_right  in  1  right input held
- airborne  in  1  Mario not on ground
- mario_x  in  10  sprite top-left X
- mario_y  in  10  sprite top-left Y
- DrawX  in  10  current beam X
- DrawY  in  10  current beam Y
- rom_addr  out  13  combinational ROM read address, fanned out to all six ROMs
- idx_runr, idx_runl, idx_standr, idx_standl, idx_jumpr, idx_jumpl  in  4 each  ROM color_idx outputs, valid one cycle after address
- color_idx  out  4  registered palette index
- sprite_on  out  1  registered; Mario pixel is opaque at this position
- pose  out  2  00 STAND, 01 RUN, 10 JUMP
- facing_left  out  1  1 = facing left

## Operation
- Pose FSM: states STAND, RUN, JUMP. Updates only on a frame_tick cycle.
  - airborne=1 → JUMP.
  - Else exactly one of move_left/move_right high → RUN.
  - Else → STAND. Both move inputs high counts as neither.
- Facing: on frame_tick, move_left&~move_right sets facing_left=1 and move_right&~move_left clears it. This applies in every state. Otherwise facing holds.
- Run phase: anim_cnt (width ≥ clog2(RUN_PERIOD)) and phase bit.
  - On a frame_tick that enters RUN from another state: anim_cnt=0, phase=0.
  - On a frame_tick while staying in RUN: if anim_cnt==RUN_PERIOD-1, clear anim_cnt and toggle phase; else increment anim_cnt.
  - Leaving RUN clears anim_cnt and phase.
- ROM select: JUMP → jump ROM. RUN with phase 0 → run ROM. RUN with phase 1 → stand ROM. STAND → stand ROM. Direction comes from facing_left.
- Hit test: use 11-bit arithmetic, so there is no wrap at 1023. inbox = DrawX≥mario_x && DrawX<mario_x+SPR_W && DrawY≥mario_y && DrawY<mario_y+SPR_H.
- Address: rom_addr = (DrawY-mario_y)*SPR_W + (DrawX-mario_x) when inbox; rom_addr = 0 otherwise. Range is 0..SPR_W*SPR_H-1.
- Pipeline stage 1 registers inbox and the 3-bit select alongside the ROM's own address register.
- Stage 2 muxes idx_* using the stage-1 select, then registers color_idx and sprite_on.
  - sprite_on = stage-1 inbox && muxed index ≠ 0. Index 0 is transparent.
  - color_idx = muxed index when inbox; color_idx = 0 otherwise.

## Timing
- Reset (async) clears: pose=STAND, facing_left=0, anim_cnt=0, phase=0, both pipeline stages, color_idx=0, sprite_on=0. rom_addr follows its inputs combinationally.
- Latency: DrawX/DrawY applied in cycle n → color_idx/sprite_on valid in cycle n+2. The palette ROM adds its own cycle downstream.
- Pose, facing and phase change only in the cycle after a frame_tick cycle. Pixels already in the pipeline keep the select captured at stage 1, so there is no mid-pixel tearing.
- frame_tick on consecutive cycles: each pulse is a separate update.
- Inputs are sampled only on frame_tick; changes between ticks have no effect.
- Reset asserted mid-line forces outputs low immediately. After release, the first valid output appears 2 cycles after the first post-reset address.

## Test plan
- Reset, then feed frame_tick with no move inputs → pose=00, facing_left=0. With mario_x=100, mario_y=200, DrawX=100, DrawY=200 → rom_addr=0, and stand-right data appears at the outputs 2 cycles later.
- Address math: mario_x=100, mario_y=200, DrawX=119, DrawY=223 → rom_addr=479, sprite_on follows idx≠0. DrawX=120 → rom_addr=0, sprite_on=0, color_idx=0 two cycles later.
- move_left=1, airborne=0, 13 frame_ticks → pose=RUN, facing_left=1. Select is run-left for ticks 1–6, stand-left for 7–12, run-left at tick 13.
- airborne=1 with move_right=1 on a tick → pose=JUMP, facing_left=0, jump-right ROM selected. Drop airborne with no moves → STAND, facing held at right.
- Both moves high on a tick → STAND, facing unchanged. idx_* value 0 in box → sprite_on=0.
- Assert Reset mid-sprite while sprite_on=1 → sprite_on and color_idx are 0 in the same cycle, and pose/facing reset. Near the right edge, mario_x=1015 with DrawX=1020 → inbox=1, no wrap.

Source files
------------

// File: rtl/mario_sprite_ctrl.sv
// -----------------------------------------------------------------------------
// mario_sprite_ctrl
//
// Sequencer for the six Mario pose ROMs (run/stand/jump x right/left).
//
// Once per video frame (on frame_tick) it decides the pose, the facing
// direction and the run-animation phase. On every pixel clock it turns the
// beam position into a ROM read address and selects the matching ROM output
// one cycle later. The result is a registered palette index plus a sprite-hit
// flag for the colour mapper.
//
// Parameters:
//   SPR_W       sprite width in pixels
//   SPR_H       sprite height in pixels (SPR_W*SPR_H must fit the 13-bit ROM
//               address space used by the pose ROMs)
//   RUN_PERIOD  frame ticks per run-animation phase (>= 1)
//
// Ports:
//   Clk            pixel/system clock, rising edge active
//   Reset          asynchronous, active-high reset
//   frame_tick     one-cycle pulse per frame (vertical blank)
//   move_left      left input held
//   move_right     right input held
//   airborne       Mario is not on the ground
//   mario_x/y      sprite top-left corner
//   DrawX/DrawY    current beam position
//   rom_addr       combinational read address, shared by all six ROMs
//   idx_*          ROM colour-index outputs, valid one cycle after rom_addr
//   color_idx      registered palette index (0 outside the sprite box)
//   sprite_on      registered opaque-pixel flag
//   pose           00 STAND, 01 RUN, 10 JUMP
//   facing_left    1 when Mario faces left
// -----------------------------------------------------------------------------
module mario_sprite_ctrl #(
  parameter int SPR_W      = 20,
  parameter int SPR_H      = 24,
  parameter int RUN_PERIOD = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        airborne,
  input  logic [9:0]  mario_x,
  input  logic [9:0]  mario_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [12:0] rom_addr,
  input  logic [3:0]  idx_runr,
  input  logic [3:0]  idx_runl,
  input  logic [3:0]  idx_standr,
  input  logic [3:0]  idx_standl,
  input  logic [3:0]  idx_jumpr,
  input  logic [3:0]  idx_jumpl,
  output logic [3:0]  color_idx,
  output logic        sprite_on,
  output logic [1:0]  pose,
  output logic        facing_left
);

  localparam int CNT_W = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_PERIOD - 1);

  // ROM select codes: the low bit is the direction (1 = left).
  localparam logic [2:0] SEL_RUNR   = 3'd0;
  localparam logic [2:0] SEL_RUNL   = 3'd1;
  localparam logic [2:0] SEL_STANDR = 3'd2;
  localparam logic [2:0] SEL_STANDL = 3'd3;
  localparam logic [2:0] SEL_JUMPR  = 3'd4;
  localparam logic [2:0] SEL_JUMPL  = 3'd5;

  typedef enum logic [1:0] {
    STAND = 2'b00,
    RUN   = 2'b01,
    JUMP  = 2'b10
  } pose_t;

  pose_t            state;
  pose_t            state_next;
  logic             facing_next;
  logic [CNT_W-1:0] anim_cnt;
  logic [CNT_W-1:0] anim_cnt_next;
  logic             phase;
  logic             phase_next;

  logic [2:0]       sel;
  logic             inbox;
  logic [12:0]      addr_calc;

  logic             s1_inbox;
  logic [2:0]       s1_sel;
  logic [3:0]       muxed_idx;

  // ---------------------------------------------------------------------------
  // Frame-rate state: pose, facing and run phase. Everything only moves on a
  // frame_tick; between ticks the move/airborne inputs are ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= STAND;
      facing_left <= 1'b0;
      anim_cnt    <= '0;
      phase       <= 1'b0;
    end else begin
      state       <= state_next;
      facing_left <= facing_next;
      anim_cnt    <= anim_cnt_next;
      phase       <= phase_next;
    end
  end

  always_comb begin
    state_next    = state;
    facing_next   = facing_left;
    anim_cnt_next = anim_cnt;
    phase_next    = phase;

    if (frame_tick) begin
      // Both move inputs high behave like neither.
      if (airborne) begin
        state_next = JUMP;
      end else if (move_left ^ move_right) begin
        state_next = RUN;
      end else begin
        state_next = STAND;
      end

      if (move_left && !move_right) begin
        facing_next = 1'b1;
      end else if (move_right && !move_left) begin
        facing_next = 1'b0;
      end

      // Entering or leaving RUN restarts the animation; staying in RUN
      // advances it and flips the phase once per RUN_PERIOD ticks.
      if (state_next == RUN && state == RUN) begin
        if (anim_cnt == CNT_LAST) begin
          anim_cnt_next = '0;
          phase_next    = ~phase;
        end else begin
          anim_cnt_next = anim_cnt + 1'b1;
        end
      end else begin
        anim_cnt_next = '0;
        phase_next    = 1'b0;
      end
    end
  end

  assign pose = state;

  // ---------------------------------------------------------------------------
  // ROM select from the current pose. Phase 1 of the run cycle reuses the
  // standing frame, which gives the two-frame run animation.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = facing_left ? SEL_STANDL : SEL_STANDR;
    case (state)
      JUMP:    sel = facing_left ? SEL_JUMPL : SEL_JUMPR;
      RUN:     if (!phase) sel = facing_left ? SEL_RUNL : SEL_RUNR;
      default: sel = facing_left ? SEL_STANDL : SEL_STANDR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hit test and address generation. Coordinates are widened to 11 bits so a
  // sprite sitting near X/Y = 1023 does not wrap its right/bottom bound.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] mx;
    logic [10:0] my;
    logic [10:0] dx;
    logic [10:0] dy;

    bx = {1'b0, DrawX};
    by = {1'b0, DrawY};
    mx = {1'b0, mario_x};
    my = {1'b0, mario_y};
    dx = bx - mx;
    dy = by - my;

    inbox = (bx >= mx) && (bx < mx + 11'(SPR_W)) &&
            (by >= my) && (by < my + 11'(SPR_H));

    addr_calc = 13'(dy) * 13'(SPR_W) + 13'(dx);
    rom_addr  = inbox ? addr_calc : 13'd0;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: travels alongside the ROMs' own address register so that the
  // select and hit flag line up with the ROM data next cycle. A pose change
  // therefore never affects a pixel already in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_inbox <= 1'b0;
      s1_sel   <= SEL_RUNR;
    end else begin
      s1_inbox <= inbox;
      s1_sel   <= sel;
    end
  end

  always_comb begin
    muxed_idx = 4'd0;
    case (s1_sel)
      SEL_RUNR:   muxed_idx = idx_runr;
      SEL_RUNL:   muxed_idx = idx_runl;
      SEL_STANDR: muxed_idx = idx_standr;
      SEL_STANDL: muxed_idx = idx_standl;
      SEL_JUMPR:  muxed_idx = idx_jumpr;
      SEL_JUMPL:  muxed_idx = idx_jumpl;
      default:    muxed_idx = 4'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered outputs. Index 0 is the transparent colour, so it
  // never raises sprite_on.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      color_idx <= 4'd0;
      sprite_on <= 1'b0;
    end else begin
      color_idx <= s1_inbox ? muxed_idx : 4'd0;
      sprite_on <= s1_inbox && (muxed_idx != 4'd0);
    end
  end

endmodule

// File: tb/tb_mario_sprite_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mario_sprite_ctrl
//
// Self-checking bench for mario_sprite_ctrl. Six behavioural pose ROMs answer
// rom_addr one cycle later with distinct data, so a wrong ROM select shows up
// as a wrong colour. Expected pixels are queued when driven and compared when
// they reach the registered outputs two cycles later.
// -----------------------------------------------------------------------------
module tb_mario_sprite_ctrl;

  logic        Clk;
  logic        Reset;
  logic        frame_tick;
  logic        move_left;
  logic        move_right;
  logic        airborne;
  logic [9:0]  mario_x;
  logic [9:0]  mario_y;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [12:0] rom_addr;
  logic [3:0]  idx_runr;
  logic [3:0]  idx_runl;
  logic [3:0]  idx_standr;
  logic [3:0]  idx_standl;
  logic [3:0]  idx_jumpr;
  logic [3:0]  idx_jumpl;
  logic [3:0]  color_idx;
  logic        sprite_on;
  logic [1:0]  pose;
  logic        facing_left;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int       due;
    logic     on;
    logic [3:0] color;
    int       tag;
  } exp_t;

  exp_t sb[$];

  // Reference state of the pose machine.
  int exp_pose  = 0;
  int exp_face  = 0;
  int exp_cnt   = 0;
  int exp_phase = 0;

  mario_sprite_ctrl #(.SPR_W(20), .SPR_H(24), .RUN_PERIOD(6)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .move_left   (move_left),
    .move_right  (move_right),
    .airborne    (airborne),
    .mario_x     (mario_x),
    .mario_y     (mario_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom_addr    (rom_addr),
    .idx_runr    (idx_runr),
    .idx_runl    (idx_runl),
    .idx_standr  (idx_standr),
    .idx_standl  (idx_standl),
    .idx_jumpr   (idx_jumpr),
    .idx_jumpl   (idx_jumpl),
    .color_idx   (color_idx),
    .sprite_on   (sprite_on),
    .pose        (pose),
    .facing_left (facing_left)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM k holds (addr + k + 1) mod 16, k = 0 runr .. 5 jumpl.
  function automatic logic [3:0] rom_fn(input int k, input int a);
    return 4'((a + k + 1) % 16);
  endfunction

  always @(posedge Clk) begin
    idx_runr   <= rom_fn(0, int'(rom_addr));
    idx_runl   <= rom_fn(1, int'(rom_addr));
    idx_standr <= rom_fn(2, int'(rom_addr));
    idx_standl <= rom_fn(3, int'(rom_addr));
    idx_jumpr  <= rom_fn(4, int'(rom_addr));
    idx_jumpl  <= rom_fn(5, int'(rom_addr));
  end

  // Output side of the scoreboard: compare every entry whose cycle is due.
  always @(posedge Clk) begin
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (sprite_on !== e.on) begin
        bad++;
        $display("[TB] FAIL sprite_on px%0d: got %b want %b", e.tag, sprite_on, e.on);
      end
      total++;
      if (color_idx !== e.color) begin
        bad++;
        $display("[TB] FAIL color_idx px%0d: got %0d want %0d", e.tag, color_idx, e.color);
      end
    end
  end

  // Which ROM the reference pose state selects.
  function automatic int model_sel();
    int base;
    if (exp_pose == 2)                         base = 4;
    else if (exp_pose == 1 && exp_phase == 0)  base = 0;
    else                                       base = 2;
    return base + exp_face;
  endfunction

  // One frame tick: update the reference, drive the pulse for one cycle.
  task automatic tick(input logic ml, input logic mr, input logic air);
    int np;
    if (air)           np = 2;
    else if (ml ^ mr)  np = 1;
    else               np = 0;
    if (ml && !mr) exp_face = 1;
    else if (mr && !ml) exp_face = 0;
    if (np == 1 && exp_pose == 1) begin
      if (exp_cnt == 5) begin
        exp_cnt   = 0;
        exp_phase = 1 - exp_phase;
      end else begin
        exp_cnt++;
      end
    end else begin
      exp_cnt   = 0;
      exp_phase = 0;
    end
    exp_pose   = np;
    move_left  = ml;
    move_right = mr;
    airborne   = air;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  // One beam position for one cycle; checks the address now, queues the output.
  task automatic pixel(input int x, input int y, input int tag);
    int   mx;
    int   my;
    int   addr;
    logic in;
    exp_t e;
    mx = int'(mario_x);
    my = int'(mario_y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    in = (x >= mx) && (x < mx + 20) && (y >= my) && (y < my + 24);
    addr = in ? (y - my) * 20 + (x - mx) : 0;
    #1;
    total++;
    if (rom_addr !== 13'(addr)) begin
      bad++;
      $display("[TB] FAIL rom_addr px%0d: got %0d want %0d", tag, rom_addr, addr);
    end
    e.due   = cyc + 2;
    e.tag   = tag;
    e.color = in ? rom_fn(model_sel(), addr) : 4'd0;
    e.on    = in && (e.color != 4'd0);
    sb.push_back(e);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic check_pose(input int tag);
    total++;
    if (pose !== 2'(exp_pose)) begin
      bad++;
      $display("[TB] FAIL pose t%0d: got %0d want %0d", tag, pose, exp_pose);
    end
    total++;
    if (facing_left !== 1'(exp_face)) begin
      bad++;
      $display("[TB] FAIL facing t%0d: got %b want %0d", tag, facing_left, exp_face);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #2;
    total++;
    if (sprite_on !== 1'b0 || color_idx !== 4'd0) begin
      bad++;
      $display("[TB] FAIL reset_out: got on=%b idx=%0d want 0/0", sprite_on, color_idx);
    end
    check_pose(0);
    @(negedge Clk);
    Reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    check_pose(1);
    mario_x = 10'd100;
    mario_y = 10'd200;
    pixel(100, 200, 1);
    idle(3);
  endtask

  task automatic test_address();
    pixel(119, 223, 10);
    pixel(120, 223, 11);
    pixel(99, 200, 12);
    pixel(100, 224, 13);
    pixel(100, 199, 14);
    pixel(110, 212, 15);
    idle(3);
  endtask

  task automatic test_run();
    for (int i = 1; i <= 13; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      check_pose(100 + i);
      pixel(105, 210, 100 + i);
    end
    idle(3);
  endtask

  task automatic test_jump();
    tick(1'b0, 1'b1, 1'b1);
    check_pose(200);
    pixel(105, 210, 200);
    pixel(119, 200, 201);
    tick(1'b0, 1'b0, 1'b0);
    check_pose(202);
    pixel(105, 210, 202);
    idle(3);
  endtask

  task automatic test_both();
    tick(1'b1, 1'b0, 1'b0);
    check_pose(300);
    tick(1'b1, 1'b1, 1'b0);
    check_pose(301);
    pixel(112, 200, 302);
    pixel(113, 200, 303);
    idle(3);
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_pose(400);
    pixel(105, 210, 400);
    // Inputs changing without a tick must be ignored.
    move_left  = 1'b1;
    move_right = 1'b0;
    airborne   = 1'b1;
    idle(3);
    check_pose(401);
    pixel(106, 210, 401);
    move_left = 1'b0;
    airborne  = 1'b0;
    idle(3);
  endtask

  task automatic test_edge();
    mario_x = 10'd1015;
    mario_y = 10'd200;
    pixel(1020, 200, 500);
    pixel(1023, 210, 501);
    pixel(1014, 210, 502);
    idle(3);
    mario_x = 10'd100;
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 1'b0);
    pixel(100, 200, 600);
    idle(3);
    @(posedge Clk);
    #3;
    total++;
    if (sprite_on !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset_on: got %b want 1", sprite_on);
    end
    Reset = 1'b1;
    #1;
    exp_pose  = 0;
    exp_face  = 0;
    exp_cnt   = 0;
    exp_phase = 0;
    total++;
    if (sprite_on !== 1'b0 || color_idx !== 4'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset_out: got on=%b idx=%0d want 0/0", sprite_on, color_idx);
    end
    check_pose(601);
    @(negedge Clk);
    Reset = 1'b0;
    pixel(100, 200, 602);
    pixel(101, 201, 603);
    idle(3);
  endtask

  initial begin
    frame_tick = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    airborne   = 1'b0;
    mario_x    = 10'd0;
    mario_y    = 10'd0;
    DrawX      = 10'd0;
    DrawY      = 10'd0;
    test_reset();
    test_address();
    test_run();
    test_jump();
    test_both();
    test_back_to_back();
    test_edge();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
